// File: rtl/fifo_wr_driver.sv
// Write-side traffic generator for async FIFO benches: emits bursts of a
// deterministic incrementing data sequence, honours full, and counts progress and stalls.
module fifo_wr_driver #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_WORDS  = 256,
    parameter int                    BURST_LEN  = 16,
    parameter int                    GAP_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED  = 'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  full,
    output logic                  wr_en,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           words_sent,
    output logic [15:0]           stall_cycles
);

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

    localparam logic [15:0] LAST_WORD = 16'(NUM_WORDS);
    localparam logic [15:0] BURST_END = 16'(BURST_LEN);
    localparam logic [15:0] GAP_LAST  = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t                state, state_nxt;
    logic [15:0]           burst_cnt, burst_cnt_nxt;
    logic [15:0]           gap_cnt, gap_cnt_nxt;
    logic                  wr_en_nxt;
    logic [DATA_WIDTH-1:0] wr_data_nxt;
    logic [15:0]           words_nxt, stall_nxt;
    logic                  busy_nxt, done_nxt;
    logic                  accept, last_word, burst_end;

    assign accept    = wr_en && !full;
    assign last_word = (words_sent + 16'd1) == LAST_WORD;
    assign burst_end = (burst_cnt + 16'd1) == BURST_END;

    // NOTE: every output is a flop loaded from a *_nxt value, so neither full nor
    // start has a combinational path to a port; sequential state uses <= only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_sent   <= '0;
            stall_cycles <= '0;
            burst_cnt    <= '0;
            gap_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            wr_en        <= wr_en_nxt;
            wr_data      <= wr_data_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            words_sent   <= words_nxt;
            stall_cycles <= stall_nxt;
            burst_cnt    <= burst_cnt_nxt;
            gap_cnt      <= gap_cnt_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned
    // (which would infer a latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = BURST;
            BURST: begin
                if (accept) begin
                    if (last_word)                         state_nxt = DONE;
                    else if (burst_end && GAP_CYCLES > 0)  state_nxt = GAP;
                end
            end
            GAP: if (gap_cnt == GAP_LAST) state_nxt = BURST;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_en_nxt     = wr_en;
        wr_data_nxt   = wr_data;
        words_nxt     = words_sent;
        stall_nxt     = stall_cycles;
        burst_cnt_nxt = burst_cnt;
        gap_cnt_nxt   = gap_cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    wr_en_nxt     = 1'b1;
                    wr_data_nxt   = DATA_SEED;
                    words_nxt     = '0;
                    stall_nxt     = '0;
                    burst_cnt_nxt = '0;
                    gap_cnt_nxt   = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    words_nxt     = words_sent + 16'd1;
                    burst_cnt_nxt = burst_cnt + 16'd1;
                    if (last_word) begin
                        wr_en_nxt = 1'b0;
                    end else begin
                        // Data advances even into a gap, so re-entry presents the next word.
                        wr_data_nxt = wr_data + DATA_WIDTH'(1);
                        if (burst_end) begin
                            burst_cnt_nxt = '0;
                            if (GAP_CYCLES > 0) begin
                                wr_en_nxt   = 1'b0;
                                gap_cnt_nxt = '0;
                            end
                        end
                    end
                end else if (wr_en && full && stall_cycles != 16'hFFFF) begin
                    stall_nxt = stall_cycles + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    wr_en_nxt     = 1'b1;
                    burst_cnt_nxt = '0;
                end else begin
                    gap_cnt_nxt = gap_cnt + 16'd1;
                end
            end
            default: wr_en_nxt = 1'b0;
        endcase
        busy_nxt = (state_nxt == BURST) || (state_nxt == GAP);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_fifo_wr_driver.sv
// Directed bench for fifo_wr_driver: three configurations (plain, gapped, wrapping)
// exercised with hand-computed data sequences, back-pressure and async reset.
module tb_fifo_wr_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Basic: 8 words, one burst, no gap.
    logic a_rst, a_start, a_full, a_en, a_busy, a_done;
    logic [7:0]  a_data;
    logic [15:0] a_words, a_stall;
    fifo_wr_driver #(.DATA_WIDTH(8), .NUM_WORDS(8), .BURST_LEN(8), .GAP_CYCLES(0), .DATA_SEED(8'hA5)) u_basic (
        .clk(clk), .rst(a_rst), .start(a_start), .full(a_full), .wr_en(a_en), .wr_data(a_data),
        .busy(a_busy), .done(a_done), .words_sent(a_words), .stall_cycles(a_stall));

    // Gapped: 32 words in bursts of 16 with 4 idle cycles.
    logic g_rst, g_start, g_full, g_en, g_busy, g_done;
    logic [7:0]  g_data;
    logic [15:0] g_words, g_stall;
    fifo_wr_driver #(.DATA_WIDTH(8), .NUM_WORDS(32), .BURST_LEN(16), .GAP_CYCLES(4), .DATA_SEED(8'hA5)) u_gap (
        .clk(clk), .rst(g_rst), .start(g_start), .full(g_full), .wr_en(g_en), .wr_data(g_data),
        .busy(g_busy), .done(g_done), .words_sent(g_words), .stall_cycles(g_stall));

    // Wrap: seed FE, 4 words.
    logic w_rst, w_start, w_full, w_en, w_busy, w_done;
    logic [7:0]  w_data;
    logic [15:0] w_words, w_stall;
    fifo_wr_driver #(.DATA_WIDTH(8), .NUM_WORDS(4), .BURST_LEN(4), .GAP_CYCLES(0), .DATA_SEED(8'hFE)) u_wrap (
        .clk(clk), .rst(w_rst), .start(w_start), .full(w_full), .wr_en(w_en), .wr_data(w_data),
        .busy(w_busy), .done(w_done), .words_sent(w_words), .stall_cycles(w_stall));

    task automatic basic_run(input string tag);
        for (int i = 0; i < 8; i++) begin
            check({tag, " en"},    a_en, 1);
            check({tag, " data"},  a_data, 8'hA5 + 8'(i));
            check({tag, " words"}, a_words, i);
            a_start = (i == 3);  // must be ignored mid-burst
            @(negedge clk);
        end
        a_start = 1'b0;
        check({tag, " done"},  a_done, 1);
        check({tag, " en_off"}, a_en, 0);
        check({tag, " busy_off"}, a_busy, 0);
        check({tag, " words_final"}, a_words, 8);
        check({tag, " stall"}, a_stall, 0);
    endtask

    initial begin
        logic [7:0] exp_d;
        int w, stalls;

        a_rst = 1'b1; g_rst = 1'b1; w_rst = 1'b1;
        a_start = 1'b0; g_start = 1'b0; w_start = 1'b0;
        a_full = 1'b0; g_full = 1'b0; w_full = 1'b0;
        @(negedge clk);
        check("rst en", a_en, 0);
        check("rst data", a_data, 0);
        check("rst busy_done", {a_busy, a_done}, 0);
        check("rst counters", {a_words, a_stall}, 0);
        a_rst = 1'b0; g_rst = 1'b0; w_rst = 1'b0;
        @(negedge clk);
        check("idle en", a_en, 0);

        // Basic run, then a second identical run launched from DONE.
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        check("run1 busy", a_busy, 1);
        basic_run("run1");
        @(negedge clk); @(negedge clk);
        check("done hold", a_done, 1);
        check("done words hold", a_words, 8);
        a_start = 1'b1; @(negedge clk); a_start = 1'b0;
        check("run2 cleared done", a_done, 0);
        basic_run("run2");

        // Gapped run: 16 words, 4 idle cycles, 16 words, no trailing gap.
        g_start = 1'b1; @(negedge clk); g_start = 1'b0;
        for (int j = 0; j < 36; j++) begin
            check("gap busy", g_busy, 1);
            check("gap en", g_en, (j < 16 || j >= 20) ? 1 : 0);
            if (j < 16 || j >= 20) begin
                exp_d = 8'hA5 + 8'((j < 16) ? j : j - 4);
                check("gap data", g_data, exp_d);
            end
            @(negedge clk);
        end
        check("gap done", g_done, 1);
        check("gap en_off", g_en, 0);
        check("gap words", g_words, 32);

        // Back-pressure: full for 5 cycles mid-burst, data must freeze.
        g_start = 1'b1; @(negedge clk); g_start = 1'b0;
        check("bp words_clr", g_words, 0);
        check("bp stall_clr", g_stall, 0);
        w = 0; stalls = 0;
        for (int j = 0; j < 40 && w < 16; j++) begin
            check("bp en", g_en, 1);
            check("bp data", g_data, 8'hA5 + 8'(w));
            g_full = (j >= 3 && j < 8);
            if (g_full) stalls++;
            else        w++;
            @(negedge clk);
        end
        g_full = 1'b0;
        check("bp accepted", w, 16);
        check("bp stall", g_stall, 5);
        check("bp words", g_words, 16);
        check("bp gap en", g_en, 0);
        check("bp next data", g_data, 8'hA5 + 8'd16);

        // Async reset mid-burst after 10 words, then a clean restart.
        g_rst = 1'b1; @(negedge clk); g_rst = 1'b0; @(negedge clk);
        g_start = 1'b1; @(negedge clk); g_start = 1'b0;
        for (int j = 0; j < 10; j++) begin
            check("pre_rst data", g_data, 8'hA5 + 8'(j));
            @(negedge clk);
        end
        check("pre_rst words", g_words, 10);
        #2 g_rst = 1'b1;
        #1;
        check("async en", g_en, 0);
        check("async data", g_data, 0);
        check("async flags", {g_busy, g_done}, 0);
        check("async counters", {g_words, g_stall}, 0);
        @(negedge clk); g_rst = 1'b0; @(negedge clk);
        g_start = 1'b1; @(negedge clk); g_start = 1'b0;
        check("restart en", g_en, 1);
        check("restart data", g_data, 8'hA5);
        check("restart words", g_words, 0);

        // Data wrap from FE.
        w_start = 1'b1; @(negedge clk); w_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_d = 8'hFE + 8'(i);
            check("wrap data", w_data, exp_d);
            check("wrap en", w_en, 1);
            @(negedge clk);
        end
        check("wrap done", w_done, 1);
        check("wrap words", w_words, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
